// File: rtl/host_descriptor_enqueue.sv
// Host-path descriptor enqueue: steers TS descriptors to per-flow submit slots,
// and NTS descriptors plus overflowed TS free-markers into a fall-through FIFO.
module host_descriptor_enqueue #(
  parameter int unsigned BUFID_W   = 9,
  parameter int unsigned PORT_W    = 4,
  parameter int unsigned TS_FLOW_N = 32,
  parameter int unsigned TS_AW     = 5,
  parameter int unsigned NTS_DEPTH = 16,
  parameter int unsigned NTS_AW    = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [BUFID_W-1:0]          iv_bufid,
  input  logic [2:0]                  iv_pkt_type,
  input  logic [PORT_W-1:0]           iv_pkt_inport,
  input  logic [TS_AW-1:0]            iv_ts_submit_addr,
  input  logic                        i_data_wr,
  input  logic                        i_ts_release,
  input  logic [TS_AW-1:0]            iv_ts_release_addr,
  output logic [PORT_W+BUFID_W-1:0]   ov_ts_descriptor_wdata,
  output logic [TS_AW-1:0]            ov_ts_descriptor_waddr,
  output logic                        o_ts_descriptor_wr,
  output logic [PORT_W+BUFID_W-1:0]   ov_nts_descriptor,
  output logic                        o_nts_valid,
  input  logic                        i_nts_ready,
  output logic [TS_FLOW_N-1:0]        ov_ts_occupancy,
  output logic                        o_ts_overflow_pulse,
  output logic                        o_nts_discard_pulse,
  output logic [CNT_W-1:0]            ov_ts_overflow_cnt,
  output logic [CNT_W-1:0]            ov_nts_discard_cnt
);

  localparam int unsigned DESC_W = PORT_W + BUFID_W;
  localparam int unsigned CW     = NTS_AW + 1;

  logic [DESC_W-1:0]    r_mem [NTS_DEPTH];
  logic [NTS_AW-1:0]    r_wr_ptr;
  logic [NTS_AW-1:0]    r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_nts_valid;
  logic [TS_FLOW_N-1:0] r_occ;
  logic [DESC_W-1:0]    r_ts_wdata;
  logic [TS_AW-1:0]     r_ts_waddr;
  logic                 r_ts_wr;
  logic                 r_ovf_pulse;
  logic                 r_disc_pulse;
  logic [CNT_W-1:0]     r_ovf_cnt;
  logic [CNT_W-1:0]     r_disc_cnt;

  logic                 w_is_ts;
  logic                 w_addr_ok;
  logic                 w_slot_busy;
  logic                 w_ts_accept;
  logic                 w_ts_ovf;
  logic                 w_push_req;
  logic                 w_full;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic [DESC_W-1:0]    w_push_data;
  logic [TS_FLOW_N-1:0] w_rel_mask;
  logic [TS_FLOW_N-1:0] w_set_mask;
  logic [TS_FLOW_N-1:0] w_occ_eff;
  logic [CW-1:0]        w_count_nxt;

  // Classification and slot lookup; a same-cycle release frees the slot first.
  always_comb begin
    w_is_ts     = (iv_pkt_type <= 3'd2);
    w_addr_ok   = (32'(iv_ts_submit_addr) < TS_FLOW_N);
    w_rel_mask  = i_ts_release ? (TS_FLOW_N'(1) << iv_ts_release_addr) : '0;
    w_occ_eff   = r_occ & ~w_rel_mask;
    w_slot_busy = w_addr_ok ? w_occ_eff[iv_ts_submit_addr] : 1'b1;
    w_ts_accept = i_data_wr & w_is_ts & ~w_slot_busy;
    w_ts_ovf    = i_data_wr & w_is_ts & w_slot_busy;
    w_set_mask  = w_ts_accept ? (TS_FLOW_N'(1) << iv_ts_submit_addr) : '0;
    w_push_req  = i_data_wr & (~w_is_ts | w_slot_busy);
    w_push_data = w_is_ts ? {{PORT_W{1'b1}}, iv_bufid} : {iv_pkt_inport, iv_bufid};
  end

  // FIFO control: a push into a full FIFO is dropped even when a pop frees space.
  always_comb begin
    w_full      = (r_count == CW'(NTS_DEPTH));
    w_push      = w_push_req & ~w_full;
    w_drop      = w_push_req & w_full;
    w_pop       = r_nts_valid & i_nts_ready;
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_nts_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + NTS_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + NTS_AW'(1);
      r_count     <= w_count_nxt;
      r_nts_valid <= (w_count_nxt != '0);
    end
  end

  // TS submit path, occupancy bitmap and event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ        <= '0;
      r_ts_wdata   <= '0;
      r_ts_waddr   <= '0;
      r_ts_wr      <= 1'b0;
      r_ovf_pulse  <= 1'b0;
      r_disc_pulse <= 1'b0;
    end else begin
      r_occ        <= w_occ_eff | w_set_mask;
      r_ts_wr      <= w_ts_accept;
      r_ts_wdata   <= w_ts_accept ? {iv_pkt_inport, iv_bufid} : '0;
      r_ts_waddr   <= w_ts_accept ? iv_ts_submit_addr : '0;
      r_ovf_pulse  <= w_ts_ovf;
      r_disc_pulse <= w_drop;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt  <= '0;
      r_disc_cnt <= '0;
    end else begin
      if (w_ts_ovf && (r_ovf_cnt != '1)) r_ovf_cnt  <= r_ovf_cnt + CNT_W'(1);
      if (w_drop && (r_disc_cnt != '1))  r_disc_cnt <= r_disc_cnt + CNT_W'(1);
    end
  end

  assign ov_ts_descriptor_wdata = r_ts_wdata;
  assign ov_ts_descriptor_waddr = r_ts_waddr;
  assign o_ts_descriptor_wr     = r_ts_wr;
  assign ov_nts_descriptor      = r_nts_valid ? r_mem[r_rd_ptr] : '0;
  assign o_nts_valid            = r_nts_valid;
  assign ov_ts_occupancy        = r_occ;
  assign o_ts_overflow_pulse    = r_ovf_pulse;
  assign o_nts_discard_pulse    = r_disc_pulse;
  assign ov_ts_overflow_cnt     = r_ovf_cnt;
  assign ov_nts_discard_cnt     = r_disc_cnt;

endmodule

// File: tb/tb_host_descriptor_enqueue.sv
// Directed bench for host_descriptor_enqueue: TS submit/overflow, NTS FIFO order,
// full-FIFO drops, pointer wrap, counter saturation and asynchronous reset.
module tb_host_descriptor_enqueue;

  logic        i_clk;
  logic        i_rst_n;
  logic [8:0]  iv_bufid;
  logic [2:0]  iv_pkt_type;
  logic [3:0]  iv_pkt_inport;
  logic [4:0]  iv_ts_submit_addr;
  logic        i_data_wr;
  logic        i_ts_release;
  logic [4:0]  iv_ts_release_addr;
  logic [12:0] ov_ts_descriptor_wdata;
  logic [4:0]  ov_ts_descriptor_waddr;
  logic        o_ts_descriptor_wr;
  logic [12:0] ov_nts_descriptor;
  logic        o_nts_valid;
  logic        i_nts_ready;
  logic [31:0] ov_ts_occupancy;
  logic        o_ts_overflow_pulse;
  logic        o_nts_discard_pulse;
  logic [15:0] ov_ts_overflow_cnt;
  logic [15:0] ov_nts_discard_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] exp_q[$];

  host_descriptor_enqueue dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .iv_bufid               (iv_bufid),
    .iv_pkt_type            (iv_pkt_type),
    .iv_pkt_inport          (iv_pkt_inport),
    .iv_ts_submit_addr      (iv_ts_submit_addr),
    .i_data_wr              (i_data_wr),
    .i_ts_release           (i_ts_release),
    .iv_ts_release_addr     (iv_ts_release_addr),
    .ov_ts_descriptor_wdata (ov_ts_descriptor_wdata),
    .ov_ts_descriptor_waddr (ov_ts_descriptor_waddr),
    .o_ts_descriptor_wr     (o_ts_descriptor_wr),
    .ov_nts_descriptor      (ov_nts_descriptor),
    .o_nts_valid            (o_nts_valid),
    .i_nts_ready            (i_nts_ready),
    .ov_ts_occupancy        (ov_ts_occupancy),
    .o_ts_overflow_pulse    (o_ts_overflow_pulse),
    .o_nts_discard_pulse    (o_nts_discard_pulse),
    .ov_ts_overflow_cnt     (ov_ts_overflow_cnt),
    .ov_nts_discard_cnt     (ov_nts_discard_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One-cycle descriptor strobe; returns on the negedge where its effect is visible.
  task automatic put(input logic [2:0] t, input logic [3:0] p, input logic [8:0] b,
                     input logic [4:0] a);
    iv_pkt_type       = t;
    iv_pkt_inport     = p;
    iv_bufid          = b;
    iv_ts_submit_addr = a;
    i_data_wr         = 1'b1;
    @(negedge i_clk);
    i_data_wr         = 1'b0;
  endtask

  task automatic fill16(input int base);
    for (int i = 0; i < 16; i++) begin
      put(3'b011, 4'(i), 9'(base + i), 5'd0);
      exp_q.push_back({4'(i), 9'(base + i)});
    end
  endtask

  task automatic drain_check(input int n, input string tag);
    i_nts_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, 32'(o_nts_valid), 32'd1);
      check({tag, "_head"}, 32'(ov_nts_descriptor), 32'(exp_q.pop_front()));
      @(negedge i_clk);
    end
    i_nts_ready = 1'b0;
    check({tag, "_empty"}, 32'(o_nts_valid), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; iv_bufid = '0; iv_pkt_type = '0; iv_pkt_inport = '0;
    iv_ts_submit_addr = '0; i_data_wr = 1'b0; i_ts_release = 1'b0;
    iv_ts_release_addr = '0; i_nts_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ts_wr", 32'(o_ts_descriptor_wr), 32'd0);
    check("rst_valid", 32'(o_nts_valid), 32'd0);
    check("rst_occ", ov_ts_occupancy, 32'd0);
    check("rst_ovf_cnt", 32'(ov_ts_overflow_cnt), 32'd0);
    check("rst_disc_cnt", 32'(ov_nts_discard_cnt), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // TS accepted into an empty slot
    put(3'b000, 4'd3, 9'h005, 5'd7);
    check("t1_wr", 32'(o_ts_descriptor_wr), 32'd1);
    check("t1_waddr", 32'(ov_ts_descriptor_waddr), 32'd7);
    check("t1_wdata", 32'(ov_ts_descriptor_wdata), 32'h605);
    check("t1_occ", ov_ts_occupancy, 32'h80);
    @(negedge i_clk);
    check("t1_wr_idle", 32'(o_ts_descriptor_wr), 32'd0);
    check("t1_wdata_idle", 32'(ov_ts_descriptor_wdata), 32'd0);

    // Same slot again: free-marker into FIFO
    put(3'b000, 4'd3, 9'h005, 5'd7);
    check("t2_ovf_pulse", 32'(o_ts_overflow_pulse), 32'd1);
    check("t2_ovf_cnt", 32'(ov_ts_overflow_cnt), 32'd1);
    check("t2_wr", 32'(o_ts_descriptor_wr), 32'd0);
    check("t2_valid", 32'(o_nts_valid), 32'd1);
    check("t2_head", 32'(ov_nts_descriptor), 32'h1E05);
    i_nts_ready = 1'b1;
    @(negedge i_clk);
    i_nts_ready = 1'b0;
    check("t2_pulse_end", 32'(o_ts_overflow_pulse), 32'd0);
    check("t2_popped", 32'(o_nts_valid), 32'd0);

    // Same slot with same-cycle release: accepted
    i_ts_release = 1'b1; iv_ts_release_addr = 5'd7;
    put(3'b010, 4'd1, 9'h0AA, 5'd7);
    i_ts_release = 1'b0;
    check("t2b_wr", 32'(o_ts_descriptor_wr), 32'd1);
    check("t2b_wdata", 32'(ov_ts_descriptor_wdata), 32'h2AA);
    check("t2b_pulse", 32'(o_ts_overflow_pulse), 32'd0);
    check("t2b_occ", ov_ts_occupancy, 32'h80);
    check("t2b_valid", 32'(o_nts_valid), 32'd0);

    // 17 NTS pushes with no consumer: 16 kept, last dropped
    fill16(16);
    put(3'b100, 4'd9, 9'h1FF, 5'd0);
    check("t3_disc_pulse", 32'(o_nts_discard_pulse), 32'd1);
    check("t3_disc_cnt", 32'(ov_nts_discard_cnt), 32'd1);
    @(negedge i_clk);
    check("t3_disc_pulse_end", 32'(o_nts_discard_pulse), 32'd0);
    drain_check(16, "t3");

    // Full FIFO: push+pop drops the push, pop still happens
    fill16(100);
    iv_pkt_type = 3'b111; iv_pkt_inport = 4'd2; iv_bufid = 9'h1AA;
    i_data_wr = 1'b1; i_nts_ready = 1'b1;
    @(negedge i_clk);
    i_data_wr = 1'b0; i_nts_ready = 1'b0;
    void'(exp_q.pop_front());
    check("t4_disc_pulse", 32'(o_nts_discard_pulse), 32'd1);
    check("t4_disc_cnt", 32'(ov_nts_discard_cnt), 32'd2);
    check("t4_head", 32'(ov_nts_descriptor), 32'(exp_q[0]));

    // 40 push+pop pairs at 15 entries: pointers wrap, count stays 15
    for (int j = 0; j < 40; j++) begin
      iv_pkt_type = 3'b101; iv_pkt_inport = 4'(j); iv_bufid = 9'(200 + j);
      i_data_wr = 1'b1; i_nts_ready = 1'b1;
      check("t4_wrap_head", 32'(ov_nts_descriptor), 32'(exp_q[0]));
      @(negedge i_clk);
      void'(exp_q.pop_front());
      exp_q.push_back({4'(j), 9'(200 + j)});
    end
    i_data_wr = 1'b0; i_nts_ready = 1'b0;
    check("t4_no_drop", 32'(ov_nts_discard_cnt), 32'd2);
    check("t4_size", 32'(exp_q.size()), 32'd15);
    drain_check(15, "t4");

    // TS overflow whose free-marker is dropped: both events counted
    fill16(300);
    put(3'b001, 4'd2, 9'h033, 5'd7);
    check("t4b_ovf_pulse", 32'(o_ts_overflow_pulse), 32'd1);
    check("t4b_disc_pulse", 32'(o_nts_discard_pulse), 32'd1);
    check("t4b_ovf_cnt", 32'(ov_ts_overflow_cnt), 32'd2);
    check("t4b_disc_cnt", 32'(ov_nts_discard_cnt), 32'd3);
    drain_check(16, "t4b");

    // Overflow counter saturation
    iv_pkt_type = 3'b000; iv_pkt_inport = 4'd1; iv_bufid = 9'h011;
    iv_ts_submit_addr = 5'd7; i_nts_ready = 1'b1; i_data_wr = 1'b1;
    repeat (65538) @(negedge i_clk);
    i_data_wr = 1'b0;
    check("t5_ovf_pulse", 32'(o_ts_overflow_pulse), 32'd1);
    check("t5_ovf_cnt", 32'(ov_ts_overflow_cnt), 32'hFFFF);
    check("t5_disc_cnt", 32'(ov_nts_discard_cnt), 32'd3);
    repeat (2) @(negedge i_clk);
    i_nts_ready = 1'b0;
    check("t5_empty", 32'(o_nts_valid), 32'd0);
    check("t5_ovf_cnt_hold", 32'(ov_ts_overflow_cnt), 32'hFFFF);

    // Asynchronous reset with queued entries and occupied slots
    for (int i = 0; i < 5; i++) put(3'b110, 4'(i), 9'(i), 5'd0);
    check("t6_pre_valid", 32'(o_nts_valid), 32'd1);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(o_nts_valid), 32'd0);
    check("t6_head", 32'(ov_nts_descriptor), 32'd0);
    check("t6_occ", ov_ts_occupancy, 32'd0);
    check("t6_ovf_cnt", 32'(ov_ts_overflow_cnt), 32'd0);
    check("t6_disc_cnt", 32'(ov_nts_discard_cnt), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("t6_post_empty", 32'(o_nts_valid), 32'd0);
    put(3'b011, 4'd5, 9'h0AB, 5'd0);
    check("t6_push_valid", 32'(o_nts_valid), 32'd1);
    check("t6_push_head", 32'(ov_nts_descriptor), 32'hAAB);
    check("t6_pulses", 32'({o_ts_overflow_pulse, o_nts_discard_pulse}), 32'd0);
    i_nts_ready = 1'b1;
    @(negedge i_clk);
    i_nts_ready = 1'b0;
    check("t6_drained", 32'(o_nts_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
